// File: rtl/fetch_pkg.sv
// Shared constants and entry type for the fetch front end.
// Imported by fetch_buf and fetch_queue.
package fetch_pkg;

    localparam int INSN_W   = 32;
    localparam int BUNDLE_W = 128;
    localparam int BUNDLE_N = 4;
    localparam int PC_STEP  = 4;

    localparam logic [INSN_W-1:0] NOP_INSN = 32'h0;

    typedef struct packed {
        logic [INSN_W-1:0] insn;
        logic [INSN_W-1:0] pc;
    } fq_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Circular instruction storage: one 4-wide write port, one 1-wide read port.
// Owns the read and write pointers; flush rewinds both to zero.
module fetch_buf
    import fetch_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                wr_en,
    input  logic [BUNDLE_W-1:0] bundle,
    input  logic [INSN_W-1:0]   base_pc,
    input  logic                rd_en,
    output fq_entry_t           head
);

    localparam int AW = $clog2(DEPTH);

    fq_entry_t     mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] widx [BUNDLE_N];
    fq_entry_t     wdat [BUNDLE_N];

    // Split the bundle into words, oldest word first, each tagged with its PC.
    always_comb begin
        for (int i = 0; i < BUNDLE_N; i++) begin
            widx[i]      = wr_ptr + AW'(i);
            wdat[i].insn = bundle[BUNDLE_W-1-INSN_W*i -: INSN_W];
            wdat[i].pc   = base_pc + INSN_W'(PC_STEP * i);
        end
    end

    // Storage array; cleared on reset so the head reads as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < DEPTH; j++) begin
                mem[j] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < BUNDLE_N; i++) begin
                mem[widx[i]] <= wdat[i];
            end
        end
    end

    // Pointer update; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(BUNDLE_N);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: drives imem_pc, queues 4-word bundles, feeds decode.
// Optional FETCHQ_STALL_CNT_EN adds a saturating decode-starvation counter.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fetch_en,
    output logic [31:0]         imem_pc,
    input  logic [BUNDLE_W-1:0] imem_bundle,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_pc,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic [INSN_W-1:0]   instr,
    output logic [31:0]         instr_pc
`ifdef FETCHQ_STALL_CNT_EN
    ,
    output logic [31:0]         stall_cnt
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] ROOM = CW'(DEPTH - BUNDLE_N);
    localparam logic [31:0] FETCH_STEP = 32'(PC_STEP * BUNDLE_N);

    logic [31:0]   pc;
    logic [CW-1:0] count;
    logic          enq;
    logic          deq;
    fq_entry_t     head;

    assign instr_valid = (count != '0);
    assign enq = fetch_en && (count <= ROOM) && !redirect_valid;
    assign deq = instr_valid && instr_ready && !redirect_valid;

    assign imem_pc  = pc;
    assign instr    = head.insn;
    assign instr_pc = head.pc;

    fetch_buf #(
        .DEPTH(DEPTH)
    ) u_buf (
        .clk    (clk),
        .rst    (rst),
        .flush  (redirect_valid),
        .wr_en  (enq),
        .bundle (imem_bundle),
        .base_pc(pc),
        .rd_en  (deq),
        .head   (head)
    );

    // Fetch PC: redirect wins, otherwise advance one bundle per enqueue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            unique case (1'b1)
                redirect_valid: pc <= redirect_pc;
                enq:            pc <= pc + FETCH_STEP;
                default:        pc <= pc;
            endcase
        end
    end

    // Occupancy: +4 per enqueue, -1 per handshake, zero on redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (redirect_valid) begin
            count <= '0;
        end else begin
            count <= count
                   + (enq ? CW'(BUNDLE_N) : CW'(0))
                   - CW'(deq);
        end
    end

`ifdef FETCHQ_STALL_CNT_EN
    // Cycles where decode wanted work but the queue was empty; saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (instr_ready && !instr_valid && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a queue-based reference model.
// Memory model: word at address A is A itself.
module tb_fetch_queue;

    localparam int DEPTH = 8;

    typedef struct {
        logic [31:0] insn;
        logic [31:0] pc;
    } ment_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          fetch_en;
    logic [31:0]   imem_pc;
    logic [127:0]  imem_bundle;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          instr_valid;
    logic          instr_ready;
    logic [31:0]   instr;
    logic [31:0]   instr_pc;
`ifdef FETCHQ_STALL_CNT_EN
    logic [31:0]   stall_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    ment_t       mq[$];
    logic [31:0] mpc = 32'd0;
    logic [31:0] mstall = 32'd0;

    fetch_queue #(
        .DEPTH(DEPTH),
        .RESET_PC(32'd0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_en      (fetch_en),
        .imem_pc       (imem_pc),
        .imem_bundle   (imem_bundle),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc)
`ifdef FETCHQ_STALL_CNT_EN
        ,
        .stall_cnt     (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    assign imem_bundle = {imem_pc, imem_pc + 32'd4,
                          imem_pc + 32'd8, imem_pc + 32'd12};

    function automatic void chk(string name, logic [31:0] got,
                                logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h @%0t",
                     name, got, exp, $time);
        end
    endfunction

    // One clock edge: model applies the rules using pre-edge inputs.
    task automatic tick();
        bit          enq;
        bit          deq;
        bit          stl;
        bit          rv;
        logic [31:0] rpc;
        ment_t       e;
        int          n;
        n   = mq.size();
        rv  = redirect_valid;
        rpc = redirect_pc;
        enq = fetch_en && (n <= DEPTH - 4) && !rv;
        deq = (n != 0) && instr_ready && !rv;
        stl = instr_ready && (n == 0);
        @(posedge clk);
        if (rv) begin
            mq.delete();
            mpc = rpc;
        end else begin
            if (deq) void'(mq.pop_front());
            if (enq) begin
                for (int i = 0; i < 4; i++) begin
                    e.pc   = mpc + 32'(4 * i);
                    e.insn = e.pc;
                    mq.push_back(e);
                end
                mpc = mpc + 32'd16;
            end
        end
        if (stl && mstall != 32'hFFFF_FFFF) mstall = mstall + 32'd1;
        #1;
    endtask

    task automatic redirect(logic [31:0] a);
        redirect_valid = 1'b1;
        redirect_pc    = a;
        tick();
        redirect_valid = 1'b0;
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("cyc_valid", {31'd0, instr_valid}, {31'd0, mq.size() != 0});
        chk("cyc_imem_pc", imem_pc, mpc);
        if (mq.size() != 0) begin
            chk("cyc_instr", instr, mq[0].insn);
            chk("cyc_instr_pc", instr_pc, mq[0].pc);
        end
`ifdef FETCHQ_STALL_CNT_EN
        chk("cyc_stall", stall_cnt, mstall);
`endif
    end

    initial begin
        rst = 1'b0;
        fetch_en = 1'b0;
        instr_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        #1 rst = 1'b1;
        #1;
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        chk("rst_imem_pc", imem_pc, 32'd0);
        #10 rst = 1'b0;

        // Streaming: one word per cycle, no gaps.
        fetch_en = 1'b1;
        instr_ready = 1'b1;
        tick();
        for (int k = 0; k < 16; k++) begin
            chk("s1_valid", {31'd0, instr_valid}, 32'd1);
            chk("s1_pc", instr_pc, 32'(4 * k));
            chk("s1_insn", instr, 32'(4 * k));
            tick();
        end

        // Back-pressure fills the queue, then drains to the refill point.
        instr_ready = 1'b0;
        redirect(32'd0);
        chk("s2_empty", {31'd0, instr_valid}, 32'd0);
        tick();
        tick();
        tick();
        chk("s2_full_pc", imem_pc, 32'd32);
        chk("s2_full_head", instr_pc, 32'd0);
        instr_ready = 1'b1;
        repeat (4) tick();
        chk("s2_hold_pc", imem_pc, 32'd32);
        chk("s2_head16", instr_pc, 32'd16);
        tick();
        chk("s2_refill_pc", imem_pc, 32'd48);
        chk("s2_head20", instr_pc, 32'd20);

        // Redirect with a live handshake at six entries.
        tick();
        redirect(32'h103);
        chk("s3_bubble", {31'd0, instr_valid}, 32'd0);
        chk("s3_imem", imem_pc, 32'h103);
        tick();
        chk("s3_valid", {31'd0, instr_valid}, 32'd1);
        chk("s3_insn0", instr, 32'h103);
        chk("s3_pc0", instr_pc, 32'h103);
        tick();
        chk("s3_insn1", instr, 32'h107);

        // PC wraps through zero.
        instr_ready = 1'b0;
        redirect(32'hFFFF_FFF8);
        tick();
        chk("s4_next", imem_pc, 32'h8);
        chk("s4_w0", instr_pc, 32'hFFFF_FFF8);
        fetch_en = 1'b0;
        instr_ready = 1'b1;
        tick();
        chk("s4_w1", instr_pc, 32'hFFFF_FFFC);
        tick();
        chk("s4_w2", instr_pc, 32'h0);
        chk("s4_nop", instr, 32'h0);
        tick();
        chk("s4_w3", instr_pc, 32'h4);
        tick();
        chk("s4_drained", {31'd0, instr_valid}, 32'd0);
        fetch_en = 1'b1;
        instr_ready = 1'b0;
        redirect(32'hFFFF_FFF0);
        tick();
        chk("s4_wrap0", imem_pc, 32'h0);

        // Single bundle then fetch disabled.
        instr_ready = 1'b1;
        redirect(32'd0);
        tick();
        fetch_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("s5_pc", instr_pc, 32'(4 * k));
            tick();
        end
        chk("s5_empty", {31'd0, instr_valid}, 32'd0);
        chk("s5_imem", imem_pc, 32'd16);
        repeat (3) tick();
        chk("s5_still_empty", {31'd0, instr_valid}, 32'd0);
        chk("s5_still_pc", imem_pc, 32'd16);

        // Asynchronous reset in the middle of a full queue.
        fetch_en = 1'b1;
        instr_ready = 1'b0;
        tick();
        tick();
        #2 rst = 1'b1;
        mq.delete();
        mpc = 32'd0;
        mstall = 32'd0;
        #1;
        chk("mr_valid", {31'd0, instr_valid}, 32'd0);
        chk("mr_imem", imem_pc, 32'd0);
        chk("mr_instr", instr, 32'd0);
        #2 rst = 1'b0;
        fetch_en = 1'b0;

`ifdef FETCHQ_STALL_CNT_EN
        instr_ready = 1'b1;
        repeat (10) tick();
        chk("s6_stall10", stall_cnt, 32'd10);
        instr_ready = 1'b0;
        redirect(32'h40);
        chk("s6_redirect_keeps", stall_cnt, 32'd10);
`endif

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction-fetch front end that drives the PC into the 4-wide instruction memory and consumes the returned 128-bit bundle. Each bundle holds the words at PC, PC+4, PC+8 and PC+12. The block buffers those words in an instruction queue and hands them to decode one at a time over a valid/ready handshake, tagged with each word's PC. Branch redirects from execute flush the queue and restart fetch at the new PC.

## Interface
Parameters:
- DEPTH, 8: queue capacity in instructions; power of two, ≥ 4.
- RESET_PC, 32'd0: PC loaded at reset.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- fetch_en  in  1  enables new fetches; the queue still drains when low.
- imem_pc  out  32  address to instruction memory; combinational read.
- imem_bundle  in  128  [127:96]=word@imem_pc, [95:64]=@+4, [63:32]=@+8, [31:0]=@+12.
- redirect_valid  in  1  flush and restart request.
- redirect_pc  in  32  restart PC; any value, no alignment required.
- instr_valid  out  1  head entry valid.
- instr_ready  in  1  decode accepts head.
- instr  out  32  head instruction word.
- instr_pc  out  32  PC of head word.
- stall_cnt  out  32  present only with FETCHQ_STALL_CNT_EN.

## Operation
- State: fetch PC register `pc`, circular queue of DEPTH entries {insn, pc}, rd_ptr, wr_ptr, count (width $clog2(DEPTH)+1).
- imem_pc = pc (register output).
- Enqueue when fetch_en && count ≤ DEPTH−4 && !redirect_valid.
  - Writes 4 entries in order: word i gets pc+4i.
  - Then wr_ptr += 4 and pc += 16.
  - The space check uses the current count only; a same-cycle dequeue does not count as space.
- Dequeue when instr_valid && instr_ready: rd_ptr += 1.
- count_next = count + 4·enq − deq.
- instr_valid = (count != 0). instr and instr_pc come from the entry at rd_ptr.
- Redirect (highest priority):
  - pc ← redirect_pc; count, rd_ptr and wr_ptr ← 0.
  - Any enqueue or dequeue in the same cycle is suppressed. The handshake is ignored even if instr_ready was high.
- Arithmetic: 32-bit PC wraps modulo 2^32 (32'hFFFFFFF0 + 16 → 0). Pointers wrap modulo DEPTH.
- An all-zero word is a NOP and is queued like any other word; no decoding happens here.

## Timing
Reset values (asynchronous):
- pc=RESET_PC, count=0, pointers=0.
- instr_valid=0, stall_cnt=0.
- instr and instr_pc read as 0.

Latency:
- Reset deassert → first enqueue at the first edge with fetch_en=1. instr_valid rises in the following cycle.
- Redirect at edge N → imem_pc=redirect_pc after N. Enqueue at N+1. instr_valid=1 after N+1. This is one bubble cycle.

Other timing rules:
- Throughput is ≤ 1 instruction per cycle to decode. Fetch bandwidth is 4 instructions per enqueue cycle.
- Full: with count > DEPTH−4 there is no enqueue and pc holds. With count=DEPTH, instr_valid=1.
- Empty: instr_valid=0; instr_ready is ignored.
- Reset asserted mid-operation clears everything immediately; no partial bundle is retained.

## Configuration
- FETCHQ_STALL_CNT_EN defined:
  - stall_cnt port and a 32-bit counter exist.
  - The counter increments each cycle with instr_ready=1 && instr_valid=0 and saturates at 32'hFFFFFFFF.
  - Cleared only by rst; redirect does not clear it.
- Undefined: no port, no counter; behaviour otherwise identical.

## Structure
- Package fetch_pkg:
  - INSN_W=32, BUNDLE_W=128, BUNDLE_N=4, PC_STEP=4, NOP_INSN=32'h0.
  - Typedef fq_entry_t {insn, pc}.
- Sub-module fetch_buf:
  - DEPTH-entry storage with one 4-wide write port and one 1-wide read port.
  - Owns rd_ptr and wr_ptr.
- The top level owns pc, count, the redirect priority and the stall counter.

## Test plan
Memory model for all scenarios: word@addr = addr.

1. Reset, fetch_en=1, instr_ready=1 → instr/instr_pc sequence 0,4,8,… one per cycle after the first valid. No gaps once the queue has primed.
2. instr_ready=0 with DEPTH=8:
   - Two enqueues (pc 0, 16); count=8; imem_pc holds at 32.
   - Raise ready: no enqueue until count ≤ 4, then fetch at 32.
3. Redirect to 32'h103 while the queue holds 6 entries, with ready=1 the same cycle:
   - That handshake is not consumed.
   - Next cycle instr_valid=0.
   - The cycle after, instr=instr_pc=32'h103, then 32'h107.
4. Redirect to 32'hFFFFFFF8 → words FFFFFFF8, FFFFFFFC, 0, 4; next fetch at 32'h8.
5. fetch_en=0 after 1 bundle → exactly 4 instructions delivered, then instr_valid=0 and imem_pc stays 16.
6. With FETCHQ_STALL_CNT_EN: hold fetch_en=0 for 10 cycles with ready=1 and the queue empty → stall_cnt=10; a redirect leaves stall_cnt unchanged.
